// File: rtl/ula_multiciclo_if.sv
// ula_multiciclo_if
// Bundles the ALU's start request, operands and results into one bus.
//   master : control unit side (drives enableULA/regA/regB/opcode, reads results)
//   slave  : ALU side
// Signals:
//   enableULA  start request
//   regA/regB  operands, WIDTH bits
//   opcode     operation select, 4 bits
//   saidaULA   result low half / quotient
//   saidaAlta  product high half / remainder
//   ocupado    division in progress
//   pronto     one-cycle pulse when outputs and flags were updated
//   flagZero, flagCarry, flagOverflow, flagDivZero  status flags
interface ula_multiciclo_if #(
  parameter int WIDTH = 8
) ();
  logic             enableULA;
  logic [WIDTH-1:0] regA;
  logic [WIDTH-1:0] regB;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] saidaULA;
  logic [WIDTH-1:0] saidaAlta;
  logic             ocupado;
  logic             pronto;
  logic             flagZero;
  logic             flagCarry;
  logic             flagOverflow;
  logic             flagDivZero;

  modport master (
    output enableULA, regA, regB, opcode,
    input  saidaULA, saidaAlta, ocupado, pronto,
    input  flagZero, flagCarry, flagOverflow, flagDivZero
  );

  modport slave (
    input  enableULA, regA, regB, opcode,
    output saidaULA, saidaAlta, ocupado, pronto,
    output flagZero, flagCarry, flagOverflow, flagDivZero
  );
endinterface

// File: rtl/ula_multiciclo.sv
// ula_multiciclo
// Multi-cycle ALU: single-cycle logic/arithmetic/multiply and an iterative
// restoring divider (one quotient bit per clock) behind a start/pronto handshake.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high; aborts a division in progress
//   bus    ula_multiciclo_if.slave (operands, opcode, results, flags, handshake)
module ula_multiciclo #(
  parameter int WIDTH = 8
) (
  input  logic                clock,
  input  logic                reset,
  ula_multiciclo_if.slave     bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {OCIOSO, DIVIDINDO} estado_t;

  estado_t            estado_q, estado_d;
  logic [WIDTH-1:0]   saida_q, saida_d;
  logic [WIDTH-1:0]   alta_q, alta_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic               dz_q, dz_d;
  logic               pronto_q, pronto_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;

  // One restoring step: shift {rem,quo} left, trial-subtract the divisor from
  // the widened partial remainder, keep it and set the quotient bit if it fits.
  function automatic logic [2*WIDTH-1:0] passo_div(
    input logic [WIDTH-1:0] rem,
    input logic [WIDTH-1:0] quo,
    input logic [WIDTH-1:0] dvs
  );
    logic [WIDTH:0] parcial;
    logic [WIDTH:0] tentativa;
    parcial   = {rem, quo[WIDTH-1]};
    tentativa = parcial - {1'b0, dvs};
    if (!tentativa[WIDTH]) begin
      return {tentativa[WIDTH-1:0], quo[WIDTH-2:0], 1'b1};
    end
    return {parcial[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
  endfunction

  logic [WIDTH:0]          soma_ext;
  logic [WIDTH:0]          dif_ext;
  logic [2*WIDTH-1:0]      produto;
  logic signed [WIDTH-1:0] a_s, b_s, soma_s, dif_s;
  logic                    ovf_soma, ovf_dif;
  logic [2*WIDTH-1:0]      passo;

  assign soma_ext = {1'b0, bus.regA} + {1'b0, bus.regB};
  assign dif_ext  = {1'b0, bus.regA} - {1'b0, bus.regB};
  assign produto  = {{WIDTH{1'b0}}, bus.regA} * {{WIDTH{1'b0}}, bus.regB};
  assign a_s      = signed'(bus.regA);
  assign b_s      = signed'(bus.regB);
  assign soma_s   = signed'(soma_ext[WIDTH-1:0]);
  assign dif_s    = signed'(dif_ext[WIDTH-1:0]);
  // Same-sign operands giving an opposite-sign sum; for sub, differing signs
  // giving a result whose sign differs from A.
  assign ovf_soma = (a_s[WIDTH-1] == b_s[WIDTH-1]) && (soma_s[WIDTH-1] != a_s[WIDTH-1]);
  assign ovf_dif  = (a_s[WIDTH-1] != b_s[WIDTH-1]) && (dif_s[WIDTH-1] != a_s[WIDTH-1]);
  assign passo    = passo_div(rem_q, quo_q, dvs_q);

  always_comb begin
    logic             upd;
    logic [WIDTH-1:0] nv_lo, nv_hi;
    logic             nv_c, nv_v, nv_dz;

    estado_d = estado_q;
    saida_d  = saida_q;
    alta_d   = alta_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    dz_d     = dz_q;
    pronto_d = 1'b0;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    upd      = 1'b0;
    nv_lo    = '0;
    nv_hi    = '0;
    nv_c     = 1'b0;
    nv_v     = 1'b0;
    nv_dz    = 1'b0;

    case (estado_q)
      OCIOSO: begin
        if (bus.enableULA) begin
          pronto_d = 1'b1;
          upd      = 1'b1;
          case (bus.opcode)
            4'b0000: nv_lo = '0;
            4'b0001: begin
              nv_lo = soma_ext[WIDTH-1:0];
              nv_c  = soma_ext[WIDTH];
              nv_v  = ovf_soma;
            end
            4'b0010: begin
              nv_lo = dif_ext[WIDTH-1:0];
              nv_c  = dif_ext[WIDTH];
              nv_v  = ovf_dif;
            end
            4'b0011: begin
              nv_lo = produto[WIDTH-1:0];
              nv_hi = produto[2*WIDTH-1:WIDTH];
              nv_c  = |produto[2*WIDTH-1:WIDTH];
            end
            4'b0100: begin
              if (bus.regB == '0) begin
                nv_lo = '1;
                nv_hi = bus.regA;
                nv_dz = 1'b1;
              end else begin
                // Divider start: no result or pronto until the last step.
                upd      = 1'b0;
                pronto_d = 1'b0;
                estado_d = DIVIDINDO;
                rem_d    = '0;
                quo_d    = bus.regA;
                dvs_d    = bus.regB;
                cnt_d    = '0;
              end
            end
            4'b0101: nv_lo = bus.regA & bus.regB;
            4'b0110: nv_lo = bus.regA | bus.regB;
            4'b0111: nv_lo = ~bus.regA;
            4'b1000: nv_lo = bus.regA ^ bus.regB;
            4'b1001: nv_lo = ~(bus.regA ^ bus.regB);
            4'b1010: nv_lo = bus.regA;
            4'b1011: nv_lo = bus.regB;
            default: upd   = 1'b0;  // NOP: hold everything, still pulse pronto
          endcase
        end
      end

      DIVIDINDO: begin
        {rem_d, quo_d} = passo;
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == ULTIMO) begin
          estado_d = OCIOSO;
          pronto_d = 1'b1;
          upd      = 1'b1;
          nv_lo    = passo[WIDTH-1:0];
          nv_hi    = passo[2*WIDTH-1:WIDTH];
        end
      end

      default: estado_d = OCIOSO;
    endcase

    if (upd) begin
      saida_d = nv_lo;
      alta_d  = nv_hi;
      zero_d  = (nv_lo == '0);
      carry_d = nv_c;
      ovf_d   = nv_v;
      dz_d    = nv_dz;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= OCIOSO;
      saida_q  <= '0;
      alta_q   <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
      pronto_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      estado_q <= estado_d;
      saida_q  <= saida_d;
      alta_q   <= alta_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      dz_q     <= dz_d;
      pronto_q <= pronto_d;
      cnt_q    <= cnt_d;
    end
  end

  // Divider working registers: only meaningful while DIVIDINDO.
  always_ff @(posedge clock) begin
    quo_q <= quo_d;
    rem_q <= rem_d;
    dvs_q <= dvs_d;
  end

  assign bus.saidaULA     = saida_q;
  assign bus.saidaAlta    = alta_q;
  assign bus.ocupado      = (estado_q == DIVIDINDO);
  assign bus.pronto       = pronto_q;
  assign bus.flagZero     = zero_q;
  assign bus.flagCarry    = carry_q;
  assign bus.flagOverflow = ovf_q;
  assign bus.flagDivZero  = dz_q;

endmodule

// File: tb/tb_ula_multiciclo.sv
// tb_ula_multiciclo
// Directed bench for ula_multiciclo at WIDTH=8 with hand-computed expectations.
// Flags are compared packed as {flagDivZero, flagOverflow, flagCarry, flagZero}.
module tb_ula_multiciclo;

  logic clock;
  logic reset;
  int   compared;
  int   mismatched;

  ula_multiciclo_if #(.WIDTH(8)) bus ();

  ula_multiciclo #(.WIDTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.enableULA = 1'b1;
    bus.opcode    = op;
    bus.regA      = a;
    bus.regB      = b;
  endtask

  function automatic logic [3:0] flags();
    return {bus.flagDivZero, bus.flagOverflow, bus.flagCarry, bus.flagZero};
  endfunction

  logic [3:0] lg_op  [8];
  logic [7:0] lg_exp [8];

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    bus.enableULA = 1'b0;
    bus.opcode    = 4'h0;
    bus.regA      = 8'h00;
    bus.regB      = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_lo", bus.saidaULA, 8'h00);
    chk("rst_hi", bus.saidaAlta, 8'h00);
    chk("rst_flags", flags(), 4'b0000);
    chk("rst_ocupado", bus.ocupado, 1'b0);
    chk("rst_pronto", bus.pronto, 1'b0);

    // add 200+100 = 300 -> 0x2C with carry
    start(4'h1, 8'd200, 8'd100);
    tick();
    bus.enableULA = 1'b0;
    chk("add_lo", bus.saidaULA, 8'h2C);
    chk("add_flags", flags(), 4'b0010);
    chk("add_pronto", bus.pronto, 1'b1);
    tick();
    chk("add_pronto_end", bus.pronto, 1'b0);

    // sub 5-7 -> 0xFE with borrow
    start(4'h2, 8'd5, 8'd7);
    tick();
    bus.enableULA = 1'b0;
    chk("sub_lo", bus.saidaULA, 8'hFE);
    chk("sub_flags", flags(), 4'b0010);

    // add 0x7F+0x01 -> 0x80 signed overflow
    start(4'h1, 8'h7F, 8'h01);
    tick();
    bus.enableULA = 1'b0;
    chk("addovf_lo", bus.saidaULA, 8'h80);
    chk("addovf_flags", flags(), 4'b0100);

    // mul 20*20 = 0x190, then 0*9 back to back
    start(4'h3, 8'd20, 8'd20);
    tick();
    chk("mul_lo", bus.saidaULA, 8'h90);
    chk("mul_hi", bus.saidaAlta, 8'h01);
    chk("mul_flags", flags(), 4'b0010);
    start(4'h3, 8'd0, 8'd9);
    tick();
    bus.enableULA = 1'b0;
    chk("mul0_lo", bus.saidaULA, 8'h00);
    chk("mul0_hi", bus.saidaAlta, 8'h00);
    chk("mul0_flags", flags(), 4'b0001);
    chk("mul0_pronto", bus.pronto, 1'b1);

    // div 100/7 = 14 r 2, 8 cycles; operands change after accept; start at edge 3 ignored
    start(4'h4, 8'd100, 8'd7);
    tick();
    bus.enableULA = 1'b0;
    bus.regA      = 8'hAA;
    bus.regB      = 8'h01;
    chk("div_ocupado_e0", bus.ocupado, 1'b1);
    chk("div_pronto_e0", bus.pronto, 1'b0);
    for (int k = 1; k < 8; k++) begin
      if (k == 3) start(4'h1, 8'd1, 8'd1);
      tick();
      bus.enableULA = 1'b0;
      chk("div_ocupado", bus.ocupado, 1'b1);
      chk("div_pronto_low", bus.pronto, 1'b0);
      if (k == 3) chk("div_ignored_lo", bus.saidaULA, 8'h00);
    end
    tick();
    chk("div_lo", bus.saidaULA, 8'd14);
    chk("div_hi", bus.saidaAlta, 8'd2);
    chk("div_flags", flags(), 4'b0000);
    chk("div_pronto", bus.pronto, 1'b1);
    chk("div_ocupado_end", bus.ocupado, 1'b0);
    tick();
    chk("div_pronto_end", bus.pronto, 1'b0);

    // div 55/0 single cycle, then AND clears flagDivZero
    start(4'h4, 8'd55, 8'd0);
    tick();
    chk("dz_lo", bus.saidaULA, 8'hFF);
    chk("dz_hi", bus.saidaAlta, 8'd55);
    chk("dz_flags", flags(), 4'b1000);
    chk("dz_ocupado", bus.ocupado, 1'b0);
    chk("dz_pronto", bus.pronto, 1'b1);
    start(4'h5, 8'hF0, 8'h3C);
    tick();
    bus.enableULA = 1'b0;
    chk("and_lo", bus.saidaULA, 8'h30);
    chk("and_hi", bus.saidaAlta, 8'h00);
    chk("and_flags", flags(), 4'b0000);

    // logic ops back to back with A=0xC5, B=0x3A
    lg_op[0] = 4'h5; lg_exp[0] = 8'h00;
    lg_op[1] = 4'h6; lg_exp[1] = 8'hFF;
    lg_op[2] = 4'h7; lg_exp[2] = 8'h3A;
    lg_op[3] = 4'h8; lg_exp[3] = 8'hFF;
    lg_op[4] = 4'h9; lg_exp[4] = 8'h00;
    lg_op[5] = 4'hA; lg_exp[5] = 8'hC5;
    lg_op[6] = 4'hB; lg_exp[6] = 8'h3A;
    lg_op[7] = 4'h0; lg_exp[7] = 8'h00;
    for (int i = 0; i < 8; i++) begin
      start(lg_op[i], 8'hC5, 8'h3A);
      tick();
      chk("logic_lo", bus.saidaULA, lg_exp[i]);
      chk("logic_zero", bus.flagZero, (lg_exp[i] == 8'h00));
      chk("logic_pronto", bus.pronto, 1'b1);
    end
    bus.enableULA = 1'b0;

    // div 200/3 aborted by reset sampled at edge 5
    start(4'h4, 8'd200, 8'd3);
    tick();
    bus.enableULA = 1'b0;
    tick();
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_lo", bus.saidaULA, 8'h00);
    chk("abort_hi", bus.saidaAlta, 8'h00);
    chk("abort_flags", flags(), 4'b0000);
    chk("abort_ocupado", bus.ocupado, 1'b0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("abort_no_pronto", bus.pronto, 1'b0);
    end

    // reset and enable together: nothing accepted
    reset = 1'b1;
    start(4'h1, 8'd3, 8'd4);
    tick();
    reset = 1'b0;
    bus.enableULA = 1'b0;
    chk("rst_en_lo", bus.saidaULA, 8'h00);
    chk("rst_en_pronto", bus.pronto, 1'b0);

    // add 0xFF+0x01 -> 0, zero and carry; then NOP holds everything
    start(4'h1, 8'hFF, 8'h01);
    tick();
    chk("add0_lo", bus.saidaULA, 8'h00);
    chk("add0_flags", flags(), 4'b0011);
    start(4'hC, 8'h05, 8'h09);
    tick();
    bus.enableULA = 1'b0;
    chk("nop_lo", bus.saidaULA, 8'h00);
    chk("nop_hi", bus.saidaAlta, 8'h00);
    chk("nop_flags", flags(), 4'b0011);
    chk("nop_pronto", bus.pronto, 1'b1);
    tick();
    chk("nop_pronto_end", bus.pronto, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
